ccff_chain_loader: RTL and testbench

Parametrised configuration-chain loader for FPGA tiles. It drives NUM_CHAINS parallel ccff_head chains from a word-wide bitstream stream, and gates each shift with a clock-enable. An optional second pass checks the load: the chain contents are recirculated through ccff_tail and compared by CRC, so the loaded configuration is preserved. isol_n is held low (fabric isolated) until a load completes cleanly. It sits between the bitstream source and the tile configuration ports at the edge of the fabric.

---
 rtl/ccff_loader_pkg.sv | 22 ++
 rtl/ccff_chain_loader_if.sv | 23 ++
 rtl/ccff_crc16.sv | 25 ++
 rtl/ccff_chain_loader.sv | 187 ++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the controller state encoding and the serial CRC-16 step function.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first serial step of CRC-16/CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between the configuration source and the chain loader.
// The source drives data/valid; the loader returns ready.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ccff_crc16.sv
// Serial CRC-16 accumulator; clear reloads the initial value and wins over en.
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic        en,
  input  logic        clear,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge prog_clk) begin
    if (prog_reset || clear) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= crc16_step(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads NUM_CHAINS parallel ccff chains from a word stream and optionally verifies the load
// by recirculating the chains and comparing per-chain CRCs. Fabric stays isolated until clean.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = 2,
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  mode,
  ccff_chain_loader_if.slave    s,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  isol_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BEATS  = WORD_W / NUM_CHAINS;
  localparam int unsigned WORDS  = (CHAIN_LEN + BEATS - 1) / BEATS;
  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WCNT_W = $clog2(WORDS + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_VERIFY = VERIFY;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WCNT_W-1:0] WORDS_ALL = WCNT_W'(WORDS);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
  logic [WCNT_W-1:0]     words_q, words_d;
  logic [WORD_W-1:0]     buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic                  mode_q, mode_d;

  logic beat, last_of_word, verifying, start_ok, accept, crc_mismatch;

  logic [15:0] load_crc   [NUM_CHAINS];
  logic [15:0] verify_crc [NUM_CHAINS];

  assign beat         = (state_q == ST_LOAD) && buf_valid_q;
  assign verifying    = (state_q == ST_VERIFY);
  assign last_of_word = (beat_idx_q == BEAT_LAST) || (cnt_q == CNT_LAST);
  assign start_ok     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Refill on the last used beat so consecutive words stream without a bubble.
  assign s.s_ready = (state_q == ST_LOAD) && (words_q != WORDS_ALL) &&
                     (!buf_valid_q || last_of_word);
  assign accept    = s.s_valid && s.s_ready;

  assign ccff_shift_en = beat || verifying;
  assign busy          = (state_q == ST_LOAD) || verifying;
  assign done          = (state_q == ST_DONE);
  assign error         = done && mode_q && crc_mismatch;
  assign isol_n        = done && !error;

  // Head holds its last driven value whenever no beat is in progress.
  always_comb begin
    if (verifying) begin
      ccff_head = ccff_tail;
    end else if (beat) begin
      ccff_head = buf_q[NUM_CHAINS-1:0];
    end else begin
      ccff_head = head_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_idx_d  = beat_idx_q;
    words_d     = words_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    head_d      = head_q;
    mode_d      = mode_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          mode_d      = mode;
          cnt_d       = '0;
          beat_idx_d  = '0;
          words_d     = '0;
          buf_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          head_d     = ccff_head;
          cnt_d      = cnt_q + 1'b1;
          buf_d      = buf_q >> NUM_CHAINS;
          beat_idx_d = beat_idx_q + 1'b1;
          if (last_of_word) begin
            // Any bits past the chain end in the final word are dropped here.
            buf_valid_d = 1'b0;
            beat_idx_d  = '0;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? ST_VERIFY : ST_DONE;
          end
        end
        if (accept) begin
          buf_d       = s.s_data;
          buf_valid_d = 1'b1;
          beat_idx_d  = '0;
          words_d     = words_q + 1'b1;
        end
      end
      ST_VERIFY: begin
        head_d = ccff_head;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      beat_idx_q  <= '0;
      words_q     <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      head_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_idx_q  <= beat_idx_d;
      words_q     <= words_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      head_q      <= head_d;
      mode_q      <= mode_d;
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : gen_chain
    ccff_crc16 u_load_crc (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .en         (beat),
      .clear      (start_ok),
      .din        (ccff_head[c]),
      .crc        (load_crc[c])
    );

    ccff_crc16 u_verify_crc (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .en         (verifying),
      .clear      (start_ok),
      .din        (ccff_tail[c]),
      .crc        (verify_crc[c])
    );
  end

  always_comb begin
    crc_mismatch = 1'b0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      if (load_crc[c] != verify_crc[c]) begin
        crc_mismatch = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with NUM_CHAINS=2, CHAIN_LEN=8, WORD_W=8.
// Chains are modelled as 8-bit shift registers fed from ccff_head.
module tb_ccff_chain_loader;

  localparam int unsigned NC = 2;
  localparam int unsigned CL = 8;
  localparam int unsigned WW = 8;

  logic          prog_clk = 1'b0;
  logic          prog_reset, start, mode;
  logic [NC-1:0] ccff_head, ccff_tail;
  logic          ccff_shift_en, isol_n, busy, done, error;

  ccff_chain_loader_if #(.WORD_W(WW)) sif ();

  ccff_chain_loader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .WORD_W     (WW)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .mode          (mode),
    .s             (sif),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en),
    .isol_n        (isol_n),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chain model; the first bit shifted in ends up at bit 7.
  logic [7:0] chain0 = 8'h00;
  logic [7:0] chain1 = 8'h00;
  logic       stuck  = 1'b0;
  assign ccff_tail = {stuck ? 1'b0 : chain1[7], chain0[7]};

  int         cyc       = 0;
  int         nsh       = 0;
  int         start_cyc = 0;
  int         done_cyc  = 0;
  logic       done_prev = 1'b0;
  logic [1:0] hlog [256];
  int         slog [256];
  logic       se_s = 1'b0;
  logic [1:0] head_s = 2'b00;

  always @(negedge prog_clk) begin
    cyc++;
    se_s   = ccff_shift_en;
    head_s = ccff_head;
    if (start === 1'b1) start_cyc = cyc;
    if (done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = (done === 1'b1);
    if (ccff_shift_en === 1'b1) begin
      if (nsh < 256) begin
        hlog[nsh] = ccff_head;
        slog[nsh] = cyc;
      end
      nsh++;
    end
  end

  always @(posedge prog_clk) begin
    if (se_s === 1'b1) begin
      chain0 <= {chain0[6:0], head_s[0]};
      chain1 <= {chain1[6:0], head_s[1]};
    end
  end

  task automatic send_word(input logic [7:0] w);
    int n = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = w;
    @(negedge prog_clk);
    while (!sif.s_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (!sif.s_ready) check("ready_timeout", 32'(sif.s_ready), 32'd1);
    @(posedge prog_clk);
    #1;
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge prog_clk);
    while (!sif.s_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (!sif.s_ready) check("gap_ready_timeout", 32'(sif.s_ready), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge prog_clk);
    while (!done && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    #1;
  endtask

  task automatic pulse_start(input logic m);
    @(posedge prog_clk);
    #1;
    start = 1'b1;
    mode  = m;
    @(posedge prog_clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(sif.s_ready), 32'd1);
    check("start_isol", 32'(isol_n), 32'd0);
    check("start_done_clr", 32'(done), 32'd0);
  endtask

  task automatic run_load(input logic m, input int gap, output int base);
    base = nsh;
    pulse_start(m);
    send_word(8'hA5);
    if (gap > 0) begin
      wait_ready();
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    send_word(8'h3C);
    wait_done();
  endtask

  task automatic check_heads(input string tag, input int base);
    logic [7:0] h0, h1;
    for (int i = 0; i < 8; i++) begin
      h0[i] = hlog[base + i][0];
      h1[i] = hlog[base + i][1];
    end
    check({tag, "_head0"}, 32'(h0), 32'h63);
    check({tag, "_head1"}, 32'(h1), 32'h6C);
  endtask

  initial begin
    int base;
    prog_reset  = 1'b1;
    start       = 1'b0;
    mode        = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    repeat (2) @(posedge prog_clk);
    #1;
    check("rst_ready", 32'(sif.s_ready), 32'd0);
    check("rst_head", 32'(ccff_head), 32'd0);
    check("rst_shift", 32'(ccff_shift_en), 32'd0);
    check("rst_isol", 32'(isol_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    prog_reset = 1'b0;

    // Load only, back-to-back words.
    run_load(1'b0, 0, base);
    check("b2b_shifts", 32'(nsh - base), 32'd8);
    check("b2b_contig", 32'(slog[base + 7] - slog[base] + 1), 32'd8);
    check_heads("b2b", base);
    check("b2b_latency", 32'(slog[base + 7] - start_cyc), 32'd9);
    check("b2b_done_cyc", 32'(done_cyc - slog[base + 7]), 32'd1);
    check("b2b_isol", 32'(isol_n), 32'd1);
    check("b2b_error", 32'(error), 32'd0);
    check("b2b_chain0", 32'(chain0), 32'hC6);
    check("b2b_chain1", 32'(chain1), 32'h36);

    // Stream stalls for 3 cycles between words.
    run_load(1'b0, 3, base);
    check("stall_shifts", 32'(nsh - base), 32'd8);
    check("stall_gap", 32'(slog[base + 7] - slog[base] + 1 - 8), 32'd3);
    check_heads("stall", base);
    check("stall_isol", 32'(isol_n), 32'd1);
    check("stall_chain0", 32'(chain0), 32'hC6);

    // Load + verify, fault-free chains.
    run_load(1'b1, 0, base);
    check("ver_shifts", 32'(nsh - base), 32'd16);
    check("ver_latency", 32'(slog[base + 15] - start_cyc), 32'd17);
    check_heads("ver", base);
    check("ver_error", 32'(error), 32'd0);
    check("ver_isol", 32'(isol_n), 32'd1);
    check("ver_chain0", 32'(chain0), 32'hC6);
    check("ver_chain1", 32'(chain1), 32'h36);

    // Load + verify with chain 1 output stuck at 0.
    stuck = 1'b1;
    run_load(1'b1, 0, base);
    check("stuck_shifts", 32'(nsh - base), 32'd16);
    check("stuck_error", 32'(error), 32'd1);
    check("stuck_isol", 32'(isol_n), 32'd0);
    check("stuck_done", 32'(done), 32'd1);
    stuck = 1'b0;

    // Reset after three LOAD beats.
    base = nsh;
    pulse_start(1'b0);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hA5;
    for (int n = 0; n < 50 && (nsh - base) < 3; n++) begin
      @(negedge prog_clk);
      #1;
    end
    check("rst_mid_beats", 32'(nsh - base), 32'd3);
    prog_reset = 1'b1;
    @(posedge prog_clk);
    #1;
    prog_reset  = 1'b0;
    sif.s_valid = 1'b0;
    check("rst_mid_shift", 32'(ccff_shift_en), 32'd0);
    check("rst_mid_ready", 32'(sif.s_ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_isol", 32'(isol_n), 32'd0);
    check("rst_mid_head", 32'(ccff_head), 32'd0);

    run_load(1'b1, 0, base);
    check("reload_shifts", 32'(nsh - base), 32'd16);
    check("reload_error", 32'(error), 32'd0);
    check("reload_isol", 32'(isol_n), 32'd1);
    check("reload_chain0", 32'(chain0), 32'hC6);
    check("reload_chain1", 32'(chain1), 32'h36);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
